irq_controller: RTL and testbench
=================================

# irq_controller

Parametrised multi-channel interrupt controller: the successor to the single-channel edge flagger. It synchronises NUM_CH asynchronous request lines and detects per-channel rising/falling edges or levels. Requests are latched into a pending register and presented to the CPU core as one prioritised, vectored request with an ack / end-of-interrupt handshake. It sits between peripheral interrupt sources and the CPU control unit.

## Interface
- NUM_CH, 8: number of interrupt channels (1..32).
- SYNC_STAGES, 2: synchroniser flops per input (>=2).
- ID_W, derived: NUM_CH>1 ? $clog2(NUM_CH) : 1.

- clk  in  1  single clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- irq_in  in  NUM_CH  raw asynchronous interrupt lines.
- rise_en  in  NUM_CH  per-channel rising-edge detect enable (edge mode).
- fall_en  in  NUM_CH  per-channel falling-edge detect enable (edge mode).
- level_mode  in  NUM_CH  1 = level-sensitive channel, 0 = edge.
- level_pol  in  NUM_CH  active level for level channels (1 = high).
- irq_enable  in  NUM_CH  per-channel delivery enable to the CPU.
- pending_clr  in  NUM_CH  write-1-to-clear pulse for edge-mode pending bits.
- irq_ack  in  1  CPU accepts the presented request.
- irq_eoi  in  1  CPU end-of-interrupt pulse.
- irq_req  out  1  request to CPU.
- irq_id  out  ID_W  channel number of the presented/in-service request.
- in_service  out  1  a request was acked and has no EOI yet.
- pending  out  NUM_CH  raw pending register, unmasked by irq_enable.

## Operation
- Per channel: SYNC_STAGES-flop synchroniser, then a history flop. rise = rise_en & s & ~h; fall = fall_en & ~s & h.
- Edge channel pending: set on rise|fall; cleared by pending_clr[i], or by irq_ack when i == irq_id. Set beats clear in the same cycle.
- Level channel pending: registered (s == level_pol). pending_clr and ack have no effect; the source must deassert.
- Eligible = pending & irq_enable. Priority is fixed: lowest index wins.
- FSM states:
  - IDLE: irq_req=0. If any eligible bit is set, latch irq_id = lowest eligible index and go to REQ.
  - REQ: irq_req=1, irq_id held stable.
    - If irq_ack: go to ACTIVE (ack has priority over withdrawal).
    - Else if the latched channel is no longer eligible (disabled or level dropped): withdraw, go to IDLE, irq_req=0 next cycle.
    - A higher-priority arrival does not pre-empt the presented id.
  - ACTIVE: irq_req=0, in_service=1, irq_id held. On irq_eoi go to IDLE. No nesting.
- irq_ack outside REQ and irq_eoi outside ACTIVE are ignored.
- Reset: all sync/history flops 0, pending=0, FSM=IDLE, irq_req=0, irq_id=0, in_service=0. An input already high at release is seen as a rising edge.

## Timing
- SYNC_STAGES=2; irq_in changes before edge 0:
  - s valid after edge 1.
  - pending[i]=1 after edge 2.
  - irq_req=1 with irq_id valid after edge 3 (FSM in IDLE).
- Ack sampled at edge A: irq_req=0 and in_service=1 after A; the edge-mode pending bit is cleared at A.
- EOI sampled at edge E: in_service=0 after E. If another channel is eligible, irq_req=1 after E+1 (one IDLE cycle).
- Each extra synchroniser stage adds one cycle to all input latencies.
- Pulses on irq_in shorter than one clk period may be lost; edges need at least 1 cycle between them to be counted distinctly.
- A repeated edge while pending is already 1 is absorbed (no counting).
- Asserting reset_n low mid-handshake returns to IDLE immediately and asynchronously; all outputs go to their reset values.

## Test plan
- Reset/release: irq_in=0, release reset_n -> pending=0, irq_req=0, irq_id=0, in_service=0 for 10 cycles.
- Rising edge on ch3 (rise_en[3]=1, irq_enable=all 1) -> pending[3]=1 after edge 2; irq_req=1, irq_id=3 after edge 3. Ack -> pending[3]=0, in_service=1. EOI -> in_service=0.
- Simultaneous rise on ch5 and ch1 -> irq_id=1 first. After ack+EOI -> irq_req=1, irq_id=5 one cycle later.
- Level channel 2 (level_mode=1, level_pol=0) held low -> ack+EOI re-presents id=2 repeatedly. Input high -> pending[2]=0 and no further request.
- Clear collision: pending_clr[4] in the same cycle as a new edge on ch4 -> pending[4] stays 1. Disable irq_enable[4] during REQ -> irq_req drops next cycle, and pending[4] stays 1.
- Async reset asserted in ACTIVE -> in_service=0 and irq_req=0 immediately. Reassert edge after release -> normal 3-cycle latency.

Source files
------------

// File: rtl/irq_controller.sv
// Multi-channel interrupt controller: per-channel synchronisation, edge/level
// detection, pending latch, and a prioritised vectored request with ack/EOI.
module irq_controller #(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] irq_in,
  input  logic [NUM_CH-1:0] rise_en,
  input  logic [NUM_CH-1:0] fall_en,
  input  logic [NUM_CH-1:0] level_mode,
  input  logic [NUM_CH-1:0] level_pol,
  input  logic [NUM_CH-1:0] irq_enable,
  input  logic [NUM_CH-1:0] pending_clr,
  input  logic              irq_ack,
  input  logic              irq_eoi,
  output logic              irq_req,
  output logic [ID_W-1:0]   irq_id,
  output logic              in_service,
  output logic [NUM_CH-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  logic [NUM_CH-1:0] sync_p [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_s;
  logic [NUM_CH-1:0] hist_q;
  logic [NUM_CH-1:0] rise_det, fall_det, edge_det, level_act;
  logic [NUM_CH-1:0] pending_q, pending_nxt, edge_nxt;
  logic [NUM_CH-1:0] eligible, id_onehot, ack_clr;
  logic [ID_W-1:0]   irq_id_q, lowest_id;
  logic              any_elig, cur_elig, ack_take;

  // Lowest set index wins; scanning downward leaves the lowest one last.
  function automatic logic [ID_W-1:0] lowest_index(input logic [NUM_CH-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  // Stage boundary: input synchroniser chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_p[k] <= '0;
    end else begin
      sync_p[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p[k] <= sync_p[k-1];
    end
  end

  assign sync_s = sync_p[SYNC_STAGES-1];

  // Stage boundary: history flop for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hist_q <= '0;
    else          hist_q <= sync_s;
  end

  assign rise_det  = rise_en & sync_s & ~hist_q;
  assign fall_det  = fall_en & ~sync_s & hist_q;
  assign edge_det  = rise_det | fall_det;
  assign level_act = ~(sync_s ^ level_pol);

  assign eligible = pending_q & irq_enable;
  assign any_elig = |eligible;
  assign lowest_id = lowest_index(eligible);
  assign ack_take = (state_q == REQ) && irq_ack;

  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      id_onehot[i] = (ID_W'(i) == irq_id_q);
    end
  end

  assign cur_elig = |(eligible & id_onehot);
  assign ack_clr  = ack_take ? id_onehot : '0;

  // A new edge in the same cycle as a clear keeps the bit set.
  assign edge_nxt    = edge_det | (pending_q & ~(pending_clr | ack_clr));
  assign pending_nxt = (level_mode & level_act) | (~level_mode & edge_nxt);

  // Stage boundary: pending register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending_q <= '0;
    else          pending_q <= pending_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (any_elig) state_nxt = REQ;
      REQ: begin
        if (irq_ack)        state_nxt = ACTIVE;
        else if (!cur_elig) state_nxt = IDLE;
      end
      ACTIVE:  if (irq_eoi) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The id is captured only when leaving IDLE so it stays stable through the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          irq_id_q <= '0;
    else if ((state_q == IDLE) && any_elig) irq_id_q <= lowest_id;
  end

  always_comb begin
    irq_req    = (state_q == REQ);
    in_service = (state_q == ACTIVE);
  end

  assign irq_id  = irq_id_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: latency, priority, level re-presentation,
// clear/enable interactions and asynchronous reset during a handshake.
module tb_irq_controller;

  localparam int NUM_CH = 8;
  localparam int ID_W   = 3;

  logic              clk;
  logic              reset_n;
  logic [NUM_CH-1:0] irq_in, rise_en, fall_en, level_mode, level_pol;
  logic [NUM_CH-1:0] irq_enable, pending_clr;
  logic              irq_ack, irq_eoi;
  logic              irq_req, in_service;
  logic [ID_W-1:0]   irq_id;
  logic [NUM_CH-1:0] pending;

  int tests = 0;
  int fails = 0;

  irq_controller #(.NUM_CH(NUM_CH), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .irq_in(irq_in), .rise_en(rise_en),
    .fall_en(fall_en), .level_mode(level_mode), .level_pol(level_pol),
    .irq_enable(irq_enable), .pending_clr(pending_clr), .irq_ack(irq_ack),
    .irq_eoi(irq_eoi), .irq_req(irq_req), .irq_id(irq_id),
    .in_service(in_service), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ack_cycle();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic eoi_cycle();
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    irq_in = '0; rise_en = 8'hFF; fall_en = '0; level_mode = '0; level_pol = '0;
    irq_enable = 8'hFF; pending_clr = '0; irq_ack = 1'b0; irq_eoi = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;

    // reset / release
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("rst_pending", pending, 0);
      chk("rst_req", irq_req, 0);
      chk("rst_id", irq_id, 0);
      chk("rst_insvc", in_service, 0);
    end

    // single rising edge on ch3
    irq_in[3] = 1'b1;
    tick(); chk("ch3_e0_pend", pending, 8'h00);
    tick(); chk("ch3_e1_pend", pending, 8'h00);
    tick(); chk("ch3_e2_pend", pending, 8'h08); chk("ch3_e2_req", irq_req, 0);
    tick(); chk("ch3_e3_req", irq_req, 1); chk("ch3_e3_id", irq_id, 3);
    ack_cycle();
    chk("ch3_ack_req", irq_req, 0); chk("ch3_ack_insvc", in_service, 1);
    chk("ch3_ack_pend", pending, 8'h00); chk("ch3_ack_id", irq_id, 3);
    tick(); chk("ch3_hold_insvc", in_service, 1);
    eoi_cycle();
    chk("ch3_eoi_insvc", in_service, 0); chk("ch3_eoi_req", irq_req, 0);
    irq_in[3] = 1'b0;
    repeat (3) tick();
    chk("ch3_fall_ignored", pending, 8'h00);

    // simultaneous ch5 and ch1
    irq_in = 8'h22;
    repeat (3) tick(); chk("pri_pend", pending, 8'h22);
    tick(); chk("pri_req", irq_req, 1); chk("pri_id1", irq_id, 1);
    ack_cycle(); chk("pri_ack_pend", pending, 8'h20); chk("pri_ack_insvc", in_service, 1);
    eoi_cycle(); chk("pri_idle_req", irq_req, 0); chk("pri_idle_insvc", in_service, 0);
    tick(); chk("pri_req5", irq_req, 1); chk("pri_id5", irq_id, 5);
    ack_cycle(); chk("pri_ack5_pend", pending, 8'h00);
    eoi_cycle();
    irq_in = '0;
    repeat (3) tick();
    chk("pri_quiet", irq_req, 0);

    // level channel 2, active low
    level_mode = 8'h04; level_pol = 8'h00;
    tick(); chk("lvl_pend", pending, 8'h04);
    tick(); chk("lvl_req", irq_req, 1); chk("lvl_id", irq_id, 2);
    ack_cycle(); chk("lvl_ack_pend", pending, 8'h04); chk("lvl_ack_insvc", in_service, 1);
    eoi_cycle(); chk("lvl_eoi_req", irq_req, 0);
    tick(); chk("lvl_rereq", irq_req, 1); chk("lvl_reid", irq_id, 2);
    ack_cycle(); chk("lvl_ack2_insvc", in_service, 1);
    irq_in[2] = 1'b1;
    repeat (3) tick(); chk("lvl_drop_pend", pending, 8'h00);
    eoi_cycle(); chk("lvl_eoi2_insvc", in_service, 0);
    tick(); chk("lvl_noreq_a", irq_req, 0);
    tick(); chk("lvl_noreq_b", irq_req, 0);
    level_mode = '0; irq_in[2] = 1'b0;
    repeat (4) tick();
    chk("lvl_back_pend", pending, 8'h00); chk("lvl_back_req", irq_req, 0);

    // clear collision and disable during REQ on ch4
    irq_in[4] = 1'b1;
    tick(); tick();
    pending_clr = 8'h10;
    tick(); pending_clr = '0;
    chk("col_pend", pending, 8'h10);
    tick(); chk("col_req", irq_req, 1); chk("col_id", irq_id, 4);
    irq_enable = 8'hEF;
    tick(); chk("dis_req", irq_req, 0); chk("dis_pend", pending, 8'h10);
    tick(); chk("dis_req2", irq_req, 0);
    ack_cycle(); chk("stray_ack_pend", pending, 8'h10); chk("stray_ack_insvc", in_service, 0);
    irq_in[4] = 1'b0;
    repeat (3) tick();
    irq_in[4] = 1'b1;
    tick(); tick();
    pending_clr = 8'h10;
    tick(); pending_clr = '0;
    chk("col2_pend", pending, 8'h10);
    pending_clr = 8'h10;
    tick(); pending_clr = '0;
    chk("clr_pend", pending, 8'h00);
    irq_enable = 8'hFF;

    // async reset in ACTIVE
    irq_in[0] = 1'b1;
    repeat (3) tick(); chk("ar_pend", pending, 8'h01);
    tick(); chk("ar_req", irq_req, 1); chk("ar_id", irq_id, 0);
    ack_cycle(); chk("ar_insvc", in_service, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_now_insvc", in_service, 0); chk("ar_now_req", irq_req, 0);
    chk("ar_now_pend", pending, 8'h00); chk("ar_now_id", irq_id, 0);
    irq_in = '0;
    tick();
    reset_n = 1'b1;
    irq_in[0] = 1'b1;
    tick(); tick(); chk("ar2_e1_pend", pending, 8'h00);
    tick(); chk("ar2_e2_pend", pending, 8'h01); chk("ar2_e2_req", irq_req, 0);
    tick(); chk("ar2_e3_req", irq_req, 1); chk("ar2_e3_id", irq_id, 0);
    ack_cycle();
    eoi_cycle();

    // falling edge on ch6
    rise_en = 8'hBF; fall_en = 8'h40;
    irq_in[6] = 1'b1;
    repeat (3) tick(); chk("fall_rise_ignored", pending, 8'h00);
    irq_in[6] = 1'b0;
    repeat (3) tick(); chk("fall_pend", pending, 8'h40);
    tick(); chk("fall_req", irq_req, 1); chk("fall_id", irq_id, 6);
    ack_cycle(); chk("fall_ack_pend", pending, 8'h00);
    eoi_cycle(); chk("fall_eoi_insvc", in_service, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
